hazard_detect: RTL and testbench

HAZARD_DETECT -- requirements
Module: hazard_detect

---
 rtl/hazard_detect.sv | 103 ++++++++++
 tb/tb_hazard_detect.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/hazard_detect.sv
// hazard_detect: load-use stall, taken-branch flush and fin-halt control for
// a five-stage pipeline. Steering outputs are combinational from the current
// state and inputs; the state register and event counters update on clk.
// CNT_W sets where the event counters saturate. Ports stay 16 bits wide.
module hazard_detect #(
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        idexmemrd,
    input  logic [4:0]  idexrd,
    input  logic [4:0]  ifidrs,
    input  logic [4:0]  ifidrt,
    input  logic        idrsused,
    input  logic        idrtused,
    input  logic        exbrtaken,
    input  logic        wbfin,
    output logic        ctrlsig,
    output logic        pcwr,
    output logic        ifidwr,
    output logic        ifidflush,
    output logic        halted,
    output logic [15:0] stallcnt,
    output logic [15:0] flushcnt
);

    typedef enum logic [1:0] {RUN, STALL, HALT} state_t;

    localparam logic [15:0] CNT_MAX = 16'((32'd1 << CNT_W) - 32'd1);

    state_t      state, state_nxt;
    logic        lu;
    logic        stall_inc, flush_inc;
    logic [15:0] stall_q, flush_q;

    // r0 is hardwired zero, so a load "into" it can never feed a consumer
    assign lu = idexmemrd && (idexrd != 5'd0) &&
                ((idrsused && (idexrd == ifidrs)) ||
                 (idrtused && (idexrd == ifidrt)));

    // next state and same-cycle pipeline steering; fin beats branch beats lu
    always_comb begin
        ctrlsig   = 1'b0;
        pcwr      = 1'b1;
        ifidwr    = 1'b1;
        ifidflush = 1'b0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        state_nxt = state;
        if (rst) begin
            state_nxt = RUN;
        end else begin
            case (state)
                RUN, STALL: begin
                    state_nxt = RUN;
                    if (wbfin) begin
                        ctrlsig   = 1'b1;
                        pcwr      = 1'b0;
                        ifidwr    = 1'b0;
                        ifidflush = 1'b1;
                        state_nxt = HALT;
                    end else if (exbrtaken) begin
                        ctrlsig   = 1'b1;
                        ifidflush = 1'b1;
                        flush_inc = 1'b1;
                    end else if (state == RUN && lu) begin
                        // in STALL the ID/EX slot already holds the bubble
                        ctrlsig   = 1'b1;
                        pcwr      = 1'b0;
                        ifidwr    = 1'b0;
                        stall_inc = 1'b1;
                        state_nxt = STALL;
                    end
                end
                HALT: begin
                    ctrlsig   = 1'b1;
                    pcwr      = 1'b0;
                    ifidwr    = 1'b0;
                    ifidflush = 1'b1;
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    // state register and saturating event counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            stall_q <= 16'd0;
            flush_q <= 16'd0;
        end else begin
            state <= state_nxt;
            if (stall_inc && stall_q != CNT_MAX) stall_q <= stall_q + 16'd1;
            if (flush_inc && flush_q != CNT_MAX) flush_q <= flush_q + 16'd1;
        end
    end

    assign halted   = (state == HALT);
    assign stallcnt = stall_q;
    assign flushcnt = flush_q;

endmodule

// File: tb/tb_hazard_detect.sv
// Bench for hazard_detect: a driver applies one directed vector per cycle and
// queues the hand-computed response; a monitor compares each negedge.
// A second instance with 4-bit counters exercises saturation quickly.
module tb_hazard_detect;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        idexmemrd = 1'b0;
    logic [4:0]  idexrd = '0, ifidrs = '0, ifidrt = '0;
    logic        idrsused = 1'b0, idrtused = 1'b0, exbrtaken = 1'b0, wbfin = 1'b0;
    logic        ctrlsig, pcwr, ifidwr, ifidflush, halted;
    logic [15:0] stallcnt, flushcnt;
    logic        s_ctrlsig, s_pcwr, s_ifidwr, s_ifidflush, s_halted;
    logic [15:0] s_stallcnt, s_flushcnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [4:0]  o;    // {ctrlsig, pcwr, ifidwr, ifidflush, halted}
        logic [15:0] sc, fc, ssc, sfc;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    hazard_detect dut (
        .clk(clk), .rst(rst), .idexmemrd(idexmemrd), .idexrd(idexrd),
        .ifidrs(ifidrs), .ifidrt(ifidrt), .idrsused(idrsused), .idrtused(idrtused),
        .exbrtaken(exbrtaken), .wbfin(wbfin), .ctrlsig(ctrlsig), .pcwr(pcwr),
        .ifidwr(ifidwr), .ifidflush(ifidflush), .halted(halted),
        .stallcnt(stallcnt), .flushcnt(flushcnt)
    );

    hazard_detect #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .idexmemrd(idexmemrd), .idexrd(idexrd),
        .ifidrs(ifidrs), .ifidrt(ifidrt), .idrsused(idrsused), .idrtused(idrtused),
        .exbrtaken(exbrtaken), .wbfin(wbfin), .ctrlsig(s_ctrlsig), .pcwr(s_pcwr),
        .ifidwr(s_ifidwr), .ifidflush(s_ifidflush), .halted(s_halted),
        .stallcnt(s_stallcnt), .flushcnt(s_flushcnt)
    );

    task automatic drive(input logic r, input logic mr, input logic [4:0] rd,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic ru, input logic tu, input logic br,
                         input logic fin);
        @(posedge clk);
        #1;
        rst = r; idexmemrd = mr; idexrd = rd; ifidrs = rs; ifidrt = rt;
        idrsused = ru; idrtused = tu; exbrtaken = br; wbfin = fin;
    endtask

    task automatic expect_o(input string nm, input logic [4:0] o,
                            input logic [15:0] sc, input logic [15:0] fc);
        exp_t e;
        e.name = nm; e.o = o; e.sc = sc; e.fc = fc;
        e.ssc = (sc > 16'd15) ? 16'd15 : sc;
        e.sfc = (fc > 16'd15) ? 16'd15 : fc;
        exp_q.push_back(e);
    endtask

    // output patterns {ctrlsig, pcwr, ifidwr, ifidflush, halted}
    localparam logic [4:0] O_RUN  = 5'b01100;
    localparam logic [4:0] O_LU   = 5'b10000;
    localparam logic [4:0] O_BR   = 5'b11110;
    localparam logic [4:0] O_FIN  = 5'b10010;
    localparam logic [4:0] O_HALT = 5'b10011;

    // monitor: every negedge with a pending expectation is one comparison
    initial begin
        exp_t e;
        logic [4:0] got, sgot;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got  = {ctrlsig, pcwr, ifidwr, ifidflush, halted};
                sgot = {s_ctrlsig, s_pcwr, s_ifidwr, s_ifidflush, s_halted};
                checks++;
                if (got !== e.o || sgot !== e.o || stallcnt !== e.sc ||
                    flushcnt !== e.fc || s_stallcnt !== e.ssc || s_flushcnt !== e.sfc) begin
                    errors++;
                    $display("FAIL %s: got o=%b so=%b sc=%0d fc=%0d ssc=%0d sfc=%0d, want o=%b sc=%0d fc=%0d ssc=%0d sfc=%0d",
                             e.name, got, sgot, stallcnt, flushcnt, s_stallcnt, s_flushcnt,
                             e.o, e.sc, e.fc, e.ssc, e.sfc);
                end
            end
        end
    end

    initial begin
        int wait_cyc;
        // reset: hazard inputs present but ignored
        drive(1, 1, 8, 8, 0, 1, 0, 0, 0); expect_o("reset_lu",      O_RUN, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); expect_o("idle",          O_RUN, 0, 0);
        // load-use on rs, held for the stall cycle
        drive(0, 1, 8, 8, 0, 1, 0, 0, 0); expect_o("lu_rs",         O_LU,  0, 0);
        drive(0, 1, 8, 8, 0, 1, 0, 0, 0); expect_o("stall_ignore",  O_RUN, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); expect_o("after_stall",   O_RUN, 1, 0);
        // no false hazards
        drive(0, 1, 0, 0, 0, 1, 1, 0, 0); expect_o("rd0_no_haz",    O_RUN, 1, 0);
        drive(0, 1, 5, 3, 5, 1, 0, 0, 0); expect_o("rt_unused",     O_RUN, 1, 0);
        // load-use on rt, then branch while in STALL
        drive(0, 1, 5, 3, 5, 0, 1, 0, 0); expect_o("lu_rt",         O_LU,  1, 0);
        drive(0, 1, 5, 3, 5, 0, 1, 1, 0); expect_o("br_in_stall",   O_BR,  2, 0);
        // lu and branch together from RUN: branch wins
        drive(0, 1, 8, 8, 0, 1, 0, 1, 0); expect_o("lu_and_br",     O_BR,  2, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); expect_o("after_br",      O_RUN, 2, 2);
        // halt from STALL, wbfin beats lu
        drive(0, 1, 8, 8, 0, 1, 0, 0, 0); expect_o("lu_pre_halt",   O_LU,  2, 2);
        drive(0, 1, 8, 8, 0, 1, 0, 0, 1); expect_o("fin_in_stall",  O_FIN, 3, 2);
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 8, 8, 0, 1, 0, logic'(i[0]), 0);
            expect_o("halt_hold", O_HALT, 3, 2);
        end
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0); expect_o("rst_in_halt",   O_RUN, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); expect_o("post_halt_rst", O_RUN, 0, 0);
        // halt from RUN, wbfin beats branch
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1); expect_o("fin_and_br",    O_FIN, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); expect_o("halted",        O_HALT, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0); expect_o("rst2",          O_RUN, 0, 0);
        // async reset asserted between edges while in STALL
        drive(0, 1, 8, 8, 0, 1, 0, 0, 0); expect_o("lu_pre_rst",    O_LU,  0, 0);
        drive(1, 1, 8, 8, 0, 1, 0, 0, 0); expect_o("async_rst",     O_RUN, 0, 0);
        drive(0, 1, 8, 8, 0, 1, 0, 0, 0); expect_o("run_after_rst", O_LU,  0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); expect_o("stall_idle",    O_RUN, 1, 0);
        // saturation: 20 lu events and 20 branches; 4-bit instance holds at 15
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0); expect_o("rst_sat",       O_RUN, 0, 0);
        for (int i = 0; i < 40; i++) begin
            drive(0, 1, 8, 8, 0, 1, 0, 0, 0);
            if (i % 2 == 0) expect_o("sat_lu",    O_LU,  16'(i / 2), 0);
            else            expect_o("sat_stall", O_RUN, 16'((i + 1) / 2), 0);
        end
        for (int j = 0; j < 20; j++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
            expect_o("sat_br", O_BR, 20, 16'(j));
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); expect_o("sat_final",     O_RUN, 20, 20);

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        #1;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
